movement_queue: RTL and testbench

- Parametrised successor to the single-register direction latch in the snake game input path.
- Decodes PS/2 set-2 byte streams, including E0 extended prefixes and F0 break codes, into direction requests.
- Rejects reversals against the most recently queued direction and buffers up to DEPTH turns.
- Applies exactly one turn per game tick, so fast key sequences (e.g. UP then LEFT within one tick) are not lost. Also provides a pause toggle and a flush for new-game.
- Sits between the PS/2 receiver and the game-logic step engine.

---
 rtl/movement_queue_pkg.sv | 45 ++++
 rtl/movement_queue_if.sv | 27 ++
 rtl/movement_queue_decoder.sv | 46 ++++
 rtl/movement_queue.sv | 94 +++++++++
 tb/tb_movement_queue.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/movement_queue_pkg.sv
// Shared key codes, direction encoding and helpers for the snake input path.
package movement_queue_pkg;

  typedef enum logic [1:0] {
    MOVEMENT_UP    = 2'd0,
    MOVEMENT_DOWN  = 2'd1,
    MOVEMENT_LEFT  = 2'd2,
    MOVEMENT_RIGHT = 2'd3
  } movement_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] KEYBOARD_ARROW_UP     = 8'h75;
  localparam logic [7:0] KEYBOARD_ARROW_DOWN   = 8'h72;
  localparam logic [7:0] KEYBOARD_ARROW_LEFT   = 8'h6B;
  localparam logic [7:0] KEYBOARD_ARROW_RIGHT  = 8'h74;
  localparam logic [7:0] KEYBOARD_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] KEYBOARD_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] KEYBOARD_SPACE        = 8'h29;

  // Opposites share the axis bit and differ in the sense bit.
  function automatic logic is_opposite(input movement_t a, input movement_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == KEYBOARD_ARROW_UP)   || (code == KEYBOARD_ARROW_DOWN) ||
           (code == KEYBOARD_ARROW_LEFT) || (code == KEYBOARD_ARROW_RIGHT);
  endfunction

  function automatic movement_t arrow_dir(input logic [7:0] code);
    case (code)
      KEYBOARD_ARROW_UP:   return MOVEMENT_UP;
      KEYBOARD_ARROW_DOWN: return MOVEMENT_DOWN;
      KEYBOARD_ARROW_LEFT: return MOVEMENT_LEFT;
      default:             return MOVEMENT_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/movement_queue_if.sv
// Byte/tick inputs and direction/status outputs of the movement queue.
interface movement_queue_if
  import movement_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    received_data;
  logic          received_data_en;
  logic          step_i;
  logic          flush_i;
  movement_t     movement_o;
  logic          paused_o;
  logic [CW-1:0] queue_count_o;
  logic          dropped_o;

  modport master (
    output received_data, received_data_en, step_i, flush_i,
    input  movement_o, paused_o, queue_count_o, dropped_o
  );

  modport slave (
    input  received_data, received_data_en, step_i, flush_i,
    output movement_o, paused_o, queue_count_o, dropped_o
  );
endinterface

// File: rtl/movement_queue_decoder.sv
// PS/2 set-2 prefix tracker: flags make codes (plain or E0-extended), swallows breaks.
module ps2_code_decoder
  import movement_queue_pkg::*;
(
  input  logic       clk50m_i,
  input  logic       rst_n_i,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       make_valid,
  output logic       is_ext,
  output logic [7:0] code
);

  dec_state_t state, state_nxt;

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= DEC_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    make_valid = 1'b0;
    is_ext     = 1'b0;
    code       = received_data;
    if (received_data_en) begin
      case (state)
        DEC_IDLE: begin
          if (received_data == KEYBOARD_EXT_PREFIX)        state_nxt = DEC_EXT;
          else if (received_data == KEYBOARD_BREAK_PREFIX) state_nxt = DEC_BRK;
          else                                             make_valid = 1'b1;
        end
        DEC_EXT: begin
          if (received_data == KEYBOARD_BREAK_PREFIX) state_nxt = DEC_EXT_BRK;
          else if (received_data != KEYBOARD_EXT_PREFIX) begin
            make_valid = 1'b1;
            is_ext     = 1'b1;
            state_nxt  = DEC_IDLE;
          end
        end
        default: state_nxt = DEC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/movement_queue.sv
// Turn FIFO between the PS/2 decoder and the game step engine: one turn per tick.
module movement_queue
  import movement_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter movement_t   INIT_DIR     = MOVEMENT_RIGHT,
  parameter bit          EXT_REQUIRED = 1'b1,
  parameter logic [7:0]  PAUSE_CODE   = KEYBOARD_SPACE
) (
  input logic             clk50m_i,
  input logic             rst_n_i,
  movement_queue_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic          make_valid, is_ext;
  logic [7:0]    code;
  movement_t     fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_r;
  movement_t     movement_r;
  logic          paused_r, dropped_r;

  movement_t req_dir, tail;
  logic      arrow_req, pause_req, turn_ok, push, pop, drop;

  ps2_code_decoder u_decoder (
    .clk50m_i         (clk50m_i),
    .rst_n_i          (rst_n_i),
    .received_data    (bus.received_data),
    .received_data_en (bus.received_data_en),
    .make_valid       (make_valid),
    .is_ext           (is_ext),
    .code             (code)
  );

  // Tail is taken before any same-cycle pop so a turn is filtered against what was queued.
  always_comb begin
    arrow_req = make_valid && is_arrow(code) && (is_ext || !EXT_REQUIRED);
    pause_req = make_valid && !is_ext && (code == PAUSE_CODE);
    req_dir   = arrow_dir(code);
    tail      = (count_r != '0) ? fifo[wr_ptr - PTR_ONE] : movement_r;
    turn_ok   = arrow_req && !paused_r && (req_dir != tail) && !is_opposite(req_dir, tail);
    push      = turn_ok && (count_r != FULL_C);
    drop      = turn_ok && (count_r == FULL_C);
    pop       = bus.step_i && !paused_r && (count_r != '0);
  end

  always_ff @(posedge clk50m_i) begin
    if (push && !bus.flush_i) fifo[wr_ptr] <= req_dir;
  end

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      movement_r <= INIT_DIR;
      paused_r   <= 1'b0;
      dropped_r  <= 1'b0;
      count_r    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (bus.flush_i) begin
      movement_r <= INIT_DIR;
      paused_r   <= 1'b0;
      dropped_r  <= 1'b0;
      count_r    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      dropped_r <= drop;
      if (pause_req) paused_r <= ~paused_r;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        movement_r <= fifo[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.movement_o    = movement_r;
  assign bus.paused_o      = paused_r;
  assign bus.queue_count_o = count_r;
  assign bus.dropped_o     = dropped_r;

endmodule

// File: tb/tb_movement_queue.sv
// Directed bench for movement_queue; dut_a requires E0 on arrows, dut_b accepts bare arrows.
module tb_movement_queue;
  import movement_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_en, step, flush;

  int checks = 0;
  int errors = 0;

  movement_t exp_a[$];
  movement_t exp_b[$];
  movement_t cur_a, cur_b;
  logic      pz;

  always #10 clk = ~clk;

  movement_queue_if #(.DEPTH(4)) bus_a ();
  movement_queue_if #(.DEPTH(4)) bus_b ();

  assign bus_a.received_data    = rx_data;
  assign bus_a.received_data_en = rx_en;
  assign bus_a.step_i           = step;
  assign bus_a.flush_i          = flush;
  assign bus_b.received_data    = rx_data;
  assign bus_b.received_data_en = rx_en;
  assign bus_b.step_i           = step;
  assign bus_b.flush_i          = flush;

  movement_queue #(.DEPTH(4), .INIT_DIR(MOVEMENT_RIGHT), .EXT_REQUIRED(1'b1), .PAUSE_CODE(8'h29))
    dut_a (.clk50m_i(clk), .rst_n_i(rst_n), .bus(bus_a.slave));

  movement_queue #(.DEPTH(4), .INIT_DIR(MOVEMENT_RIGHT), .EXT_REQUIRED(1'b0), .PAUSE_CODE(8'h29))
    dut_b (.clk50m_i(clk), .rst_n_i(rst_n), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    check({tag, "_a_dir"},    32'(bus_a.movement_o),    32'(cur_a));
    check({tag, "_a_count"},  32'(bus_a.queue_count_o), 32'(exp_a.size()));
    check({tag, "_a_paused"}, 32'(bus_a.paused_o),      32'(pz));
  endtask

  task automatic check_b(input string tag);
    check({tag, "_b_dir"},    32'(bus_b.movement_o),    32'(cur_b));
    check({tag, "_b_count"},  32'(bus_b.queue_count_o), 32'(exp_b.size()));
    check({tag, "_b_paused"}, 32'(bus_b.paused_o),      32'(pz));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_en   = 1'b1;
    @(negedge clk);
    rx_en   = 1'b0;
  endtask

  task automatic step_tick();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    if (!pz && exp_a.size() > 0) cur_a = exp_a.pop_front();
    if (!pz && exp_b.size() > 0) cur_b = exp_b.pop_front();
  endtask

  task automatic push_both(input movement_t d);
    exp_a.push_back(d);
    exp_b.push_back(d);
  endtask

  task automatic model_clear();
    exp_a.delete();
    exp_b.delete();
    cur_a = MOVEMENT_RIGHT;
    cur_b = MOVEMENT_RIGHT;
    pz    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_en = 1'b0; step = 1'b0; flush = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_a("reset");
    check("reset_dropped", 32'(bus_a.dropped_o), 32'd0);

    repeat (3) step_tick();
    check_a("idle_steps");

    // reversal against RIGHT and an extended break are both ignored
    send(8'hE0); send(8'h6B);
    check_a("reversal");
    check("reversal_dropped", 32'(bus_a.dropped_o), 32'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_a("ext_break");

    send(8'hE0); send(8'h75); push_both(MOVEMENT_UP);
    check_a("queue_up");
    send(8'hE0); send(8'h6B); push_both(MOVEMENT_LEFT);
    check_a("queue_left");
    step_tick(); check_a("step1");
    step_tick(); check_a("step2");

    // fill the 4-deep FIFO; the fifth valid turn is dropped with a pulse
    for (int i = 0; i < 5; i++) begin
      send(8'hE0);
      send((i % 2 == 0) ? 8'h75 : 8'h74);
      if (i < 4) push_both((i % 2 == 0) ? MOVEMENT_UP : MOVEMENT_RIGHT);
      check($sformatf("drop_%0d", i), 32'(bus_a.dropped_o), (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("drop_clear", 32'(bus_a.dropped_o), 32'd0);
    check_a("full");

    send(8'h29); pz = 1'b1;
    check_a("paused");
    send(8'hE0); send(8'h72);
    step_tick();
    check_a("paused_frozen");
    send(8'h29); pz = 1'b0;
    check_a("unpaused");

    step_tick(); step_tick();
    check_a("drain2");

    @(negedge clk); flush = 1'b1; step = 1'b1;
    @(negedge clk); flush = 1'b0; step = 1'b0;
    model_clear();
    check_a("flush_step");

    // push with step on an empty queue: stored, not bypassed
    send(8'hE0);
    @(negedge clk); rx_data = 8'h75; rx_en = 1'b1; step = 1'b1;
    @(negedge clk); rx_en = 1'b0; step = 1'b0;
    push_both(MOVEMENT_UP);
    check_a("pushpop_empty");

    // LEFT filtered against queued UP, not against current RIGHT
    send(8'hE0);
    @(negedge clk); rx_data = 8'h6B; rx_en = 1'b1; step = 1'b1;
    @(negedge clk); rx_en = 1'b0; step = 1'b0;
    push_both(MOVEMENT_LEFT);
    cur_a = exp_a.pop_front();
    cur_b = exp_b.pop_front();
    check_a("pushpop_tail");
    step_tick();
    check_a("after_pushpop");
    check_b("after_pushpop");

    // reset after E0 abandons the prefix; following 75 is a bare code
    send(8'hE0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    send(8'h75);
    exp_b.push_back(MOVEMENT_UP);
    check_a("bare_ext_req");
    check_b("bare_no_ext_req");
    step_tick();
    check_a("bare_step");
    check_b("bare_step");

    send(8'hE0); send(8'h29);
    check_a("ext_space");

    send(8'h29); pz = 1'b1;
    check_a("pause_again");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    model_clear();
    check_a("flush_unpause");
    check_b("flush_unpause");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
